// File: rtl/iob_cache_arbiter.sv
// Two-master round-robin arbiter in front of a single cache frontend port.
// One access in flight at a time; the winner's request is latched and held until the cache acks.
module iob_cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,

  input  logic                m0_req_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  input  logic [DATA_W/8-1:0] m0_wstrb_i,
  output logic [DATA_W-1:0]   m0_rdata_o,
  output logic                m0_ack_o,

  input  logic                m1_req_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic [DATA_W/8-1:0] m1_wstrb_i,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                m1_ack_o,

  output logic                c_req_o,
  output logic [ADDR_W-1:0]   c_addr_o,
  output logic [DATA_W-1:0]   c_wdata_o,
  output logic [DATA_W/8-1:0] c_wstrb_o,
  input  logic [DATA_W-1:0]   c_rdata_i,
  input  logic                c_ack_i,

  output logic                grant_o,
  output logic                busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state_q;
  logic                grant_q;
  logic                last_grant_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                grant_d;

  // On a tie the master that was not served last wins.
  assign grant_d = m1_req_i & (~m0_req_i | ~last_grant_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_req_i || m1_req_i) begin
            state_q      <= BUSY;
            grant_q      <= grant_d;
            last_grant_q <= grant_d;
            addr_q       <= grant_d ? m1_addr_i  : m0_addr_i;
            wdata_q      <= grant_d ? m1_wdata_i : m0_wdata_i;
            wstrb_q      <= grant_d ? m1_wstrb_i : m0_wstrb_i;
          end
        end
        BUSY: begin
          // Always pass through IDLE so a request still high in its ack cycle is not re-issued.
          if (c_ack_i) begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy_o     = (state_q == BUSY);
  assign c_req_o    = (state_q == BUSY);
  assign c_addr_o   = addr_q;
  assign c_wdata_o  = wdata_q;
  assign c_wstrb_o  = wstrb_q;
  assign grant_o    = grant_q;

  assign m0_ack_o   = c_ack_i & busy_o & ~grant_q;
  assign m1_ack_o   = c_ack_i & busy_o &  grant_q;
  assign m0_rdata_o = c_rdata_i;
  assign m1_rdata_o = c_rdata_i;

endmodule

// File: tb/tb_iob_cache_arbiter.sv
// Directed bench for iob_cache_arbiter: reset, single/dual master handshakes, hold stability,
// mid-access reset, and a two-master write/read-back run against a small cache model.
module tb_iob_cache_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int NUM_ACC = 100;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                m0_req_i, m1_req_i;
  logic [ADDR_W-1:0]   m0_addr_i, m1_addr_i;
  logic [DATA_W-1:0]   m0_wdata_i, m1_wdata_i;
  logic [DATA_W/8-1:0] m0_wstrb_i, m1_wstrb_i;
  logic [DATA_W-1:0]   m0_rdata_o, m1_rdata_o;
  logic                m0_ack_o, m1_ack_o;
  logic                c_req_o;
  logic [ADDR_W-1:0]   c_addr_o;
  logic [DATA_W-1:0]   c_wdata_o;
  logic [DATA_W/8-1:0] c_wstrb_o;
  logic [DATA_W-1:0]   c_rdata_i;
  logic                c_ack_i;
  logic                grant_o, busy_o;

  int vectors = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] mem [int];
  logic [DATA_W-1:0] expData0 [NUM_ACC];
  logic [DATA_W-1:0] expData1 [NUM_ACC];

  always #5 clk_i = ~clk_i;

  iob_cache_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
    .m0_wstrb_i(m0_wstrb_i), .m0_rdata_o(m0_rdata_o), .m0_ack_o(m0_ack_o),
    .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_wstrb_i(m1_wstrb_i), .m1_rdata_o(m1_rdata_o), .m1_ack_o(m1_ack_o),
    .c_req_o(c_req_o), .c_addr_o(c_addr_o), .c_wdata_o(c_wdata_o),
    .c_wstrb_o(c_wstrb_o), .c_rdata_i(c_rdata_i), .c_ack_i(c_ack_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  // Inputs change 2 time units after a rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                               input logic [DATA_W/8-1:0] s0, input logic r1, input logic [ADDR_W-1:0] a1,
                               input logic [DATA_W-1:0] d1, input logic [DATA_W/8-1:0] s1);
    m0_req_i = r0; m0_addr_i = a0; m0_wdata_i = d0; m0_wstrb_i = s0;
    m1_req_i = r1; m1_addr_i = a1; m1_wdata_i = d1; m1_wstrb_i = s1;
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  // Serve one granted access with random ack latency; the bench acts as the cache.
  task automatic serve(input logic g, input logic [ADDR_W-1:0] expAddr, input logic [DATA_W-1:0] expWdata,
                       input logic isWrite, input logic [DATA_W-1:0] expRdata);
    int lat;
    step();
    settle();
    checkOutput("stress c_req", {63'd0, c_req_o}, 64'd1);
    checkOutput("stress grant", {63'd0, grant_o}, {63'd0, g});
    checkOutput("stress c_addr", {32'd0, c_addr_o}, {32'd0, expAddr});
    checkOutput("stress c_wstrb", {60'd0, c_wstrb_o}, isWrite ? 64'hF : 64'h0);
    if (isWrite) checkOutput("stress c_wdata", {32'd0, c_wdata_o}, {32'd0, expWdata});
    lat = $urandom_range(1, 5);
    repeat (lat - 1) step();
    c_ack_i = 1'b1;
    if (isWrite) begin
      mem[int'(c_addr_o)] = c_wdata_o;
      c_rdata_i = $urandom;
    end else begin
      c_rdata_i = mem.exists(int'(c_addr_o)) ? mem[int'(c_addr_o)] : 32'hDEAD_BEEF;
    end
    settle();
    checkOutput("stress m0_ack", {63'd0, m0_ack_o}, {63'd0, ~g});
    checkOutput("stress m1_ack", {63'd0, m1_ack_o}, {63'd0, g});
    if (!isWrite) checkOutput("stress rdata", {32'd0, g ? m1_rdata_o : m0_rdata_o}, {32'd0, expRdata});
    step();
    c_ack_i = 1'b0;
    if (g) m1_req_i = 1'b0; else m0_req_i = 1'b0;
    settle();
    checkOutput("stress idle gap", {63'd0, busy_o}, 64'd0);
  endtask

  initial begin
    c_ack_i = 1'b0;
    c_rdata_i = '0;
    applyStimulus(1'b0, 32'd0, 32'd0, 4'h0, 1'b0, 32'd0, 32'd0, 4'h0);
    doReset();
    settle();
    checkOutput("reset c_req", {63'd0, c_req_o}, 64'd0);
    checkOutput("reset busy", {63'd0, busy_o}, 64'd0);
    checkOutput("reset grant", {63'd0, grant_o}, 64'd0);
    checkOutput("reset c_addr", {32'd0, c_addr_o}, 64'd0);
    checkOutput("reset c_wdata", {32'd0, c_wdata_o}, 64'd0);
    checkOutput("reset c_wstrb", {60'd0, c_wstrb_o}, 64'd0);

    // Single master write.
    applyStimulus(1'b1, 32'd3, 32'd9, 4'hF, 1'b0, 32'd0, 32'd0, 4'h0);
    settle();
    checkOutput("single pre-grant c_req", {63'd0, c_req_o}, 64'd0);
    step();
    settle();
    checkOutput("single c_req", {63'd0, c_req_o}, 64'd1);
    checkOutput("single c_addr", {32'd0, c_addr_o}, 64'd3);
    checkOutput("single c_wdata", {32'd0, c_wdata_o}, 64'd9);
    checkOutput("single c_wstrb", {60'd0, c_wstrb_o}, 64'hF);
    checkOutput("single m0_ack before c_ack", {63'd0, m0_ack_o}, 64'd0);
    c_ack_i = 1'b1;
    settle();
    checkOutput("single m0_ack", {63'd0, m0_ack_o}, 64'd1);
    checkOutput("single m1_ack", {63'd0, m1_ack_o}, 64'd0);
    step();
    c_ack_i = 1'b0;
    m0_req_i = 1'b0;
    settle();
    checkOutput("single busy after ack", {63'd0, busy_o}, 64'd0);
    checkOutput("single c_req after ack", {63'd0, c_req_o}, 64'd0);

    // Stray ack while idle.
    c_ack_i = 1'b1;
    settle();
    checkOutput("idle ack m0_ack", {63'd0, m0_ack_o}, 64'd0);
    checkOutput("idle ack m1_ack", {63'd0, m1_ack_o}, 64'd0);
    step();
    c_ack_i = 1'b0;
    settle();
    checkOutput("idle ack busy", {63'd0, busy_o}, 64'd0);

    // Simultaneous requests after reset: m0 then m1.
    doReset();
    applyStimulus(1'b1, 32'd10, 32'h100, 4'hF, 1'b1, 32'd20, 32'h0, 4'h0);
    step();
    settle();
    checkOutput("tie1 grant", {63'd0, grant_o}, 64'd0);
    checkOutput("tie1 c_addr", {32'd0, c_addr_o}, 64'd10);
    c_ack_i = 1'b1;
    settle();
    checkOutput("tie1 m0_ack", {63'd0, m0_ack_o}, 64'd1);
    checkOutput("tie1 m1_ack", {63'd0, m1_ack_o}, 64'd0);
    step();
    c_ack_i = 1'b0;
    m0_req_i = 1'b0;
    settle();
    checkOutput("tie1 idle gap busy", {63'd0, busy_o}, 64'd0);
    step();
    settle();
    checkOutput("tie1 m1 busy", {63'd0, busy_o}, 64'd1);
    checkOutput("tie1 m1 grant", {63'd0, grant_o}, 64'd1);
    checkOutput("tie1 m1 c_addr", {32'd0, c_addr_o}, 64'd20);
    checkOutput("tie1 m1 c_wstrb", {60'd0, c_wstrb_o}, 64'd0);
    c_ack_i = 1'b1;
    c_rdata_i = 32'hABCD;
    settle();
    checkOutput("tie1 m1_ack", {63'd0, m1_ack_o}, 64'd1);
    checkOutput("tie1 m0_ack on m1 access", {63'd0, m0_ack_o}, 64'd0);
    checkOutput("tie1 m1_rdata", {32'd0, m1_rdata_o}, 64'hABCD);
    step();
    c_ack_i = 1'b0;
    m1_req_i = 1'b0;

    // Repeated tie alternates back to m0; then hold stability while busy.
    applyStimulus(1'b1, 32'd10, 32'h100, 4'hF, 1'b1, 32'd20, 32'h0, 4'h0);
    step();
    settle();
    checkOutput("tie2 grant", {63'd0, grant_o}, 64'd0);
    m0_addr_i = 32'd99;
    m0_wdata_i = 32'h5555;
    m1_req_i = 1'b0;
    step();
    m1_req_i = 1'b1;
    step();
    m1_req_i = 1'b0;
    settle();
    checkOutput("hold c_addr", {32'd0, c_addr_o}, 64'd10);
    checkOutput("hold c_wdata", {32'd0, c_wdata_o}, 64'h100);
    checkOutput("hold grant", {63'd0, grant_o}, 64'd0);
    checkOutput("hold busy", {63'd0, busy_o}, 64'd1);
    c_ack_i = 1'b1;
    step();
    c_ack_i = 1'b0;
    m0_req_i = 1'b0;
    step();
    settle();
    checkOutput("withdrawn m1 dropped", {63'd0, busy_o}, 64'd0);

    // last_grant is now 0, so a tie must go to m1.
    applyStimulus(1'b1, 32'd7, 32'h1, 4'hF, 1'b1, 32'd8, 32'h2, 4'h3);
    step();
    settle();
    checkOutput("tie3 grant", {63'd0, grant_o}, 64'd1);
    checkOutput("tie3 c_addr", {32'd0, c_addr_o}, 64'd8);
    checkOutput("tie3 c_wstrb", {60'd0, c_wstrb_o}, 64'h3);

    // Reset in the middle of that access, then a late ack.
    m0_req_i = 1'b0;
    m1_req_i = 1'b0;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    c_ack_i = 1'b1;
    settle();
    checkOutput("midrst m0_ack", {63'd0, m0_ack_o}, 64'd0);
    checkOutput("midrst m1_ack", {63'd0, m1_ack_o}, 64'd0);
    checkOutput("midrst c_req", {63'd0, c_req_o}, 64'd0);
    checkOutput("midrst grant", {63'd0, grant_o}, 64'd0);
    checkOutput("midrst c_addr", {32'd0, c_addr_o}, 64'd0);
    step();
    c_ack_i = 1'b0;
    applyStimulus(1'b1, 32'd1, 32'h0, 4'h0, 1'b1, 32'd2, 32'h0, 4'h0);
    step();
    settle();
    checkOutput("midrst next tie grant", {63'd0, grant_o}, 64'd0);
    c_ack_i = 1'b1;
    step();
    c_ack_i = 1'b0;
    applyStimulus(1'b0, 32'd0, 32'd0, 4'h0, 1'b0, 32'd0, 32'd0, 4'h0);
    step();

    // Both masters contend on every access; each tie alternates, so neither waits more than one foreign access.
    doReset();
    for (int i = 0; i < NUM_ACC; i++) begin
      expData0[i] = $urandom;
      expData1[i] = $urandom;
      applyStimulus(1'b1, 32'(i), expData0[i], 4'hF, 1'b1, 32'(256 + i), expData1[i], 4'hF);
      serve(1'b0, 32'(i), expData0[i], 1'b1, 32'd0);
      serve(1'b1, 32'(256 + i), expData1[i], 1'b1, 32'd0);
    end
    for (int i = 0; i < NUM_ACC; i++) begin
      applyStimulus(1'b1, 32'(i), 32'd0, 4'h0, 1'b1, 32'(256 + i), 32'd0, 4'h0);
      serve(1'b0, 32'(i), 32'd0, 1'b0, expData0[i]);
      serve(1'b1, 32'(256 + i), 32'd0, 1'b0, expData1[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
